data_memory_bus: RTL and testbench
==================================

Name: data_memory_bus

Overview:
- Data-side memory subsystem driven by the core's data memory port (mem_d_*) in the DM stage.
- Decodes each access to either a byte-maskable word RAM or a small MMIO block.
- MMIO block contains a console TX FIFO with a valid/ready output, a status register and a free-running cycle counter.
- Read data is combinational, because the DM stage consumes it in the same cycle; all writes are synchronous.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 16-byte MMIO window.
- FIFO_DEPTH, 4, console FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_d_we  in  1  write enable from core.
- mem_d_wmask  in  4  byte-lane write mask; bit i enables byte lane [8i+7:8i].
- mem_d_a  in  32  byte address from core.
- mem_d_wd  in  32  write data, already lane-aligned by core.
- mem_d_rd  out  32  read data to core (combinational).
- con_valid  out  1  console byte available.
- con_data  out  8  console byte (FIFO head).
- con_ready  in  1  console sink accepts byte.

Behaviour:
- Decode uses word address mem_d_a[31:2]; bits [1:0] are ignored for both selection and data.
  - RAM hit: mem_d_a < 4*RAM_WORDS.
  - MMIO hit: mem_d_a[31:4] == MMIO_BASE[31:4].
  - Any other address: reads return 0, writes are ignored, no side effects.
- RAM:
  - Read: mem_d_rd = ram[mem_d_a[31:2]] combinationally.
  - Write: on a clock edge with mem_d_we=1, each byte lane whose mask bit is 1 is written; lanes with mask bit 0 are untouched.
  - Contents are not cleared by reset.
  - Read-during-write to the same word returns the old value; the new value is visible the following cycle.
- MMIO offset 0x0, CONSOLE_TX:
  - A write with mask[0]=1 pushes mem_d_wd[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and ovf is set.
  - Reads return 0.
- MMIO offset 0x4, STATUS:
  - Read value: {29'b0, ovf, empty, full}.
  - A write with mask[0]=1 and mem_d_wd[2]=1 clears ovf.
  - If a set and a clear occur in the same cycle, the set wins.
- MMIO offset 0x8, CYCLE:
  - Read returns the registered 32-bit count.
  - Each cycle the count increments by 1, wrapping 32'hFFFF_FFFF -> 0.
  - A write with a nonzero mask loads the masked lanes from mem_d_wd; unmasked lanes keep their current value. No increment occurs in that cycle.
- MMIO offset 0xC: reserved; reads return 0, writes are ignored.
- Console FIFO:
  - con_valid = !empty; con_data = entry at the read pointer.
  - Pop occurs when con_valid && con_ready at the clock edge.
  - Push and pop in the same cycle:
    - When full: both proceed, count unchanged, no overflow.
    - When empty: only the push proceeds; there is no bypass, so data becomes visible on the next cycle.
  - Latency: a byte written at edge N gives con_valid=1 during cycle N+1.
  - con_data must remain stable while con_valid && !con_ready.
  - Pointers are log2(FIFO_DEPTH) bits plus one wrap bit.
- Reset values:
  - FIFO empty, con_valid=0, con_data=0.
  - ovf=0, cycle count=0.
  - mem_d_rd follows decode combinationally; it does not depend on reset.
  - A reset asserted mid-stream discards all queued bytes at that edge; a write presented in the same cycle as reset is ignored by MMIO state, but RAM writes still occur.

Optional Feature:
- Macro: DATA_MEMORY_BUS_CYCLE_CNT_EN.
- Defined: the CYCLE register behaves as described above.
- Undefined: no counter flops are instantiated; offset 0x8 reads 0 and writes to it are ignored. All other behaviour is unchanged.

Test Plan:
- RAM byte mask: write 32'hDEADBEEF to 0x10 with mask 4'b1111, then 32'h000000AA with mask 4'b0001 -> reading 0x10 returns 32'hDEADBEAA; reading 0x12 returns the same word.
- Unmapped access: write to 0x8000_0000 (RAM_WORDS=1024), then read it -> mem_d_rd=0; RAM words 0..3 unchanged.
- Console ordering/latency: hold con_ready=0, write 'H','i' to MMIO_BASE+0x0 on consecutive cycles -> con_valid rises the cycle after the first write with con_data=8'h48; raise con_ready -> 8'h48 then 8'h69 are popped, then con_valid=0.
- Overflow: con_ready=0, write 5 bytes to CONSOLE_TX -> STATUS reads 32'h5 (full, ovf). Write STATUS with wd=4 -> reads 32'h1. Drain the FIFO -> only the first 4 bytes emerge; STATUS then reads 32'h2.
- Full push+pop: with the FIFO full and con_ready=1, write a byte in the same cycle -> ovf stays 0, full stays 1, and the new byte emerges after the 3 older bytes.
- Cycle counter: write 32'hFFFF_FFFE to MMIO_BASE+0x8 with mask 4'b1111 -> reads give FFFF_FFFE, then FFFF_FFFF, then 0, then 1 on subsequent cycles. Assert reset -> the next read is 0. With the macro undefined, the read is always 0.

Source files
------------

// File: rtl/data_memory_bus.sv
// data_memory_bus: data-side RAM plus MMIO (console TX FIFO, status, cycle counter)
//   clk, reset            clock; synchronous active-high reset
//   mem_d_we/wmask/a/wd   core data port: write enable, byte mask, byte address, write data
//   mem_d_rd              combinational read data
//   con_valid/data/ready  console byte stream out of the TX FIFO
//   Macro DATA_MEMORY_BUS_CYCLE_CNT_EN enables the CYCLE counter at MMIO offset 0x8.
module data_memory_bus #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_d_we,
    input  logic [3:0]  mem_d_wmask,
    input  logic [31:0] mem_d_a,
    input  logic [31:0] mem_d_wd,
    output logic [31:0] mem_d_rd,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW:0]   wp_q, wp_d, rp_q, rp_d;
    logic          ovf_q, ovf_d;
    logic          ram_hit, mmio_hit, empty, full, push_req, push, pop, ovf_clr;
    logic [1:0]    off;
    logic [AW-1:0] ram_idx;
    logic [31:0]   cyc_rd;
    logic          unused_a;

    assign unused_a = ^mem_d_a[1:0];
    assign ram_hit  = mem_d_a[31:2] < 30'(RAM_WORDS);
    assign ram_idx  = mem_d_a[AW+1:2];
    assign mmio_hit = mem_d_a[31:4] == MMIO_BASE[31:4];
    assign off      = mem_d_a[3:2];

    // Pointers carry an extra wrap bit: equal means empty, differing only in the wrap bit means full.
    assign empty     = wp_q == rp_q;
    assign full      = (wp_q ^ rp_q) == {1'b1, PW'(0)};
    assign pop       = !empty && con_ready;
    assign push_req  = mem_d_we && mmio_hit && off == 2'd0 && mem_d_wmask[0];
    assign push      = push_req && (!full || pop);
    assign ovf_clr   = mem_d_we && mmio_hit && off == 2'd1 && mem_d_wmask[0] && mem_d_wd[2];
    assign con_valid = !empty;
    assign con_data  = empty ? 8'h00 : fifo_q[rp_q[PW-1:0]];

    always_comb begin
        wp_d  = wp_q + (PW+1)'(push);
        rp_d  = rp_q + (PW+1)'(pop);
        ovf_d = (push_req && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage arrays are not reset; RAM writes proceed even during reset, FIFO pushes do not.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_d_we && ram_hit && mem_d_wmask[i]) ram_q[ram_idx][8*i +: 8] <= mem_d_wd[8*i +: 8];
        if (push && !reset) fifo_q[wp_q[PW-1:0]] <= mem_d_wd[7:0];
    end

`ifdef DATA_MEMORY_BUS_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic        cyc_wr;

    assign cyc_wr = mem_d_we && mmio_hit && off == 2'd2 && |mem_d_wmask;

    // A load replaces the increment for that cycle; unmasked lanes hold.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_wr)
            for (int i = 0; i < 4; i++)
                cyc_d[8*i +: 8] = mem_d_wmask[i] ? mem_d_wd[8*i +: 8] : cyc_q[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    assign mem_d_rd = ram_hit      ? ram_q[ram_idx] :
                      !mmio_hit    ? 32'h0 :
                      off == 2'd1  ? {29'b0, ovf_q, empty, full} :
                      off == 2'd2  ? cyc_rd : 32'h0;
endmodule

// File: tb/tb_data_memory_bus.sv
// tb_data_memory_bus: directed table and sequence checks for data_memory_bus
module tb_data_memory_bus;
    localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DATA_MEMORY_BUS_CYCLE_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_d_we = 1'b0;
    logic [3:0]  mem_d_wmask = 4'h0;
    logic [31:0] mem_d_a = 32'h0;
    logic [31:0] mem_d_wd = 32'h0;
    logic [31:0] mem_d_rd;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    int          pass_n = 0;
    int          tot_n = 0;

    data_memory_bus dut (
        .clk(clk), .reset(reset), .mem_d_we(mem_d_we), .mem_d_wmask(mem_d_wmask),
        .mem_d_a(mem_d_a), .mem_d_wd(mem_d_wd), .mem_d_rd(mem_d_rd),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic        crd;
        logic [31:0] rd;
        logic        v;
        logic [7:0]  d;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // One cycle: drive after the rising edge, leave the caller at the falling edge to sample.
    task automatic put(input logic we, input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic rs);
        @(posedge clk);
        #1;
        mem_d_we = we; mem_d_wmask = m; mem_d_a = a; mem_d_wd = wd; con_ready = rdy; reset = rs;
        @(negedge clk);
    endtask

    task automatic con(input string nm, input logic v, input logic [7:0] d);
        chk({nm, ".valid"}, 32'(con_valid), 32'(v));
        chk({nm, ".data"}, 32'(con_data), 32'(d));
    endtask

    initial begin
        tbl = '{
            '{1'b1, 4'hF, 32'h0,         32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'hF, 32'h4,         32'h2222_2222, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'hF, 32'h8,         32'h3333_3333, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'hF, 32'hC,         32'h4444_4444, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'hF, 32'h10,        32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'h1, 32'h10,        32'h0000_00AA, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h10,        32'h0,         1'b0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h12,        32'h0,         1'b0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h00},
            '{1'b1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h4,         32'h0,         1'b0, 1'b1, 32'h2222_2222, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h8,         32'h0,         1'b0, 1'b1, 32'h3333_3333, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'hC,         32'h0,         1'b0, 1'b1, 32'h4444_4444, 1'b0, 8'h00},
            '{1'b1, 4'hF, 32'hFFC,       32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00},
            '{1'b0, 4'h0, 32'hFFC,       32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00},
            '{1'b0, 4'h0, 32'h1000,      32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b0, 1'b1, 32'h2,         1'b0, 8'h00},
            '{1'b0, 4'h0, MB + 32'hC,    32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'hF, MB + 32'hC,    32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'h1, MB,            32'h48,        1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b1, 4'h1, MB,            32'h69,        1'b0, 1'b1, 32'h0,         1'b1, 8'h48},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'h48},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h48},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h69},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b1, 1'b1, 32'h2,         1'b0, 8'h00},
            '{1'b1, 4'hE, MB,            32'h41,        1'b0, 1'b1, 32'h0,         1'b0, 8'h00},
            '{1'b0, 4'h0, MB + 32'h4,    32'h0,         1'b0, 1'b1, 32'h2,         1'b0, 8'h00}
        };
        repeat (2) @(posedge clk);

        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("reset.cycle", mem_d_rd, 32'h0);
        con("reset", 1'b0, 8'h00);

        for (int i = 0; i < 28; i++) begin
            put(tbl[i].we, tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].rdy, 1'b0);
            if (tbl[i].crd) chk($sformatf("vec%0d.rd", i), mem_d_rd, tbl[i].rd);
            con($sformatf("vec%0d", i), tbl[i].v, tbl[i].d);
        end

        for (int i = 0; i < 5; i++) put(1'b1, 4'h1, MB, 32'hA0 + 32'(i), 1'b0, 1'b0);
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b0, 1'b0);
        chk("ovf.status", mem_d_rd, 32'h5);
        put(1'b1, 4'h1, MB + 32'h4, 32'h4, 1'b0, 1'b0);
        chk("ovf.clr_cycle", mem_d_rd, 32'h5);
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b0, 1'b0);
        chk("ovf.cleared", mem_d_rd, 32'h1);
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b1, 1'b0);
            con($sformatf("ovf.drain%0d", i), 1'b1, 8'hA0 + 8'(i));
        end
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b1, 1'b0);
        chk("ovf.empty_status", mem_d_rd, 32'h2);
        con("ovf.empty", 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) put(1'b1, 4'h1, MB, 32'hB0 + 32'(i), 1'b0, 1'b0);
        put(1'b1, 4'h1, MB, 32'hB4, 1'b1, 1'b0);
        con("fpp.head", 1'b1, 8'hB0);
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b0, 1'b0);
        chk("fpp.status", mem_d_rd, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b1, 1'b0);
            con($sformatf("fpp.drain%0d", i), 1'b1, 8'hB0 + 8'(i));
        end
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b1, 1'b0);
        chk("fpp.empty_status", mem_d_rd, 32'h2);

        put(1'b1, 4'hF, MB + 32'h8, 32'hFFFF_FFFE, 1'b0, 1'b0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.load", mem_d_rd, CE ? 32'hFFFF_FFFE : 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.max", mem_d_rd, CE ? 32'hFFFF_FFFF : 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.wrap", mem_d_rd, 32'h0);
        put(1'b1, 4'h2, MB + 32'h8, 32'h0000_AB00, 1'b0, 1'b0);
        chk("cyc.one", mem_d_rd, CE ? 32'h1 : 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.partial", mem_d_rd, CE ? 32'h0000_AB01 : 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b1);
        chk("cyc.pre_reset", mem_d_rd, CE ? 32'h0000_AB02 : 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.after_reset", mem_d_rd, 32'h0);
        put(1'b0, 4'h0, MB + 32'h8, 32'h0, 1'b0, 1'b0);
        chk("cyc.after_reset1", mem_d_rd, CE ? 32'h1 : 32'h0);

        put(1'b1, 4'h1, MB, 32'hC0, 1'b0, 1'b0);
        put(1'b1, 4'h1, MB, 32'hC1, 1'b0, 1'b0);
        con("rst.queued", 1'b1, 8'hC0);
        put(1'b1, 4'h1, MB, 32'hC2, 1'b0, 1'b1);
        put(1'b1, 4'hF, 32'h20, 32'h0000_0077, 1'b0, 1'b1);
        put(1'b0, 4'h0, MB + 32'h4, 32'h0, 1'b0, 1'b0);
        chk("rst.status", mem_d_rd, 32'h2);
        con("rst.flushed", 1'b0, 8'h00);
        put(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("rst.ram_write", mem_d_rd, 32'h0000_0077);
        con("rst.still_empty", 1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
